// File: rtl/uart_num_parser_pkg.sv
// Shared constants, state and byte-class types for the UART decimal number parser.
package uart_num_parser_pkg;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LINE    = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_SP       = 8'h20;
  localparam logic [7:0] ASCII_0        = 8'h30;
  localparam logic [7:0] ASCII_9        = 8'h39;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h21;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    NUM     = 2'b01,
    DISCARD = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CLS_DIGIT   = 2'b00,
    CLS_TERM    = 2'b01,
    CLS_PRINT   = 2'b10,
    CLS_ILLEGAL = 2'b11
  } byte_class_t;

  function automatic byte_class_t classify(input logic [7:0] b);
    byte_class_t cls;
    if (b >= ASCII_0 && b <= ASCII_9) begin
      cls = CLS_DIGIT;
    end else if (b == ASCII_LF || b == ASCII_CR || b == ASCII_SP) begin
      cls = CLS_TERM;
    end else if (b >= ASCII_PRINT_LO && b <= ASCII_PRINT_HI) begin
      cls = CLS_PRINT;
    end else begin
      cls = CLS_ILLEGAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/uart_num_parser_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear and flags the final cycle of the window.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 115000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count stops at LAST so it can never wrap while the parser is still busy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_num_parser.sv
// Byte-level decimal number / command-character parser behind the UART receiver.
// Optional byte echo buffer enabled by defining NUM_PARSER_ECHO_EN.
module uart_num_parser
  import uart_num_parser_pkg::*;
#(
  parameter int VALUE_W        = 32,
  parameter int TIMEOUT_CYCLES = 115000
) (
`ifdef NUM_PARSER_ECHO_EN
  output logic [7:0]         echo_o,
  output logic               echo_valid_o,
  input  logic               echo_ready_i,
`endif
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_parity_err_i,
  input  logic               rx_frame_err_i,
  output logic [VALUE_W-1:0] value_o,
  output logic               value_valid_o,
  output logic [7:0]         char_o,
  output logic               char_valid_o,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output logic               busy_o
);

  state_t             state;
  logic [VALUE_W-1:0] acc;
  byte_class_t        cls;
  logic               line_err;
  logic [VALUE_W-1:0] digit;
  logic [VALUE_W+3:0] acc_x10;
  logic               ovf;
  logic               busy;
  logic               expire;

  assign cls      = classify(rx_data_i);
  assign line_err = rx_parity_err_i | rx_frame_err_i;
  assign digit    = VALUE_W'(rx_data_i[3:0]);
  // Four guard bits hold any acc*10+9, so overflow is simply a non-zero top nibble.
  assign acc_x10  = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {4'd0, digit};
  assign ovf      = |acc_x10[VALUE_W+3:VALUE_W];
  assign busy     = (state != IDLE);
  assign busy_o   = busy;

  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid_i),
    .enable (busy),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      acc           <= '0;
      value_o       <= '0;
      value_valid_o <= 1'b0;
      char_o        <= 8'h00;
      char_valid_o  <= 1'b0;
      err_o         <= 1'b0;
      err_code_o    <= ERR_NONE;
    end else begin
      value_valid_o <= 1'b0;
      char_valid_o  <= 1'b0;
      err_o         <= 1'b0;
      if (rx_valid_i && line_err) begin
        err_o      <= 1'b1;
        err_code_o <= ERR_LINE;
        acc        <= '0;
        state      <= IDLE;
      end else if (rx_valid_i) begin
        case (state)
          IDLE: begin
            case (cls)
              CLS_DIGIT:   begin acc <= digit; state <= NUM; end
              CLS_PRINT:   begin char_o <= rx_data_i; char_valid_o <= 1'b1; end
              CLS_ILLEGAL: begin err_o <= 1'b1; err_code_o <= ERR_ILLEGAL; end
              default:     state <= IDLE;
            endcase
          end
          NUM: begin
            case (cls)
              CLS_DIGIT: begin
                if (ovf) begin
                  err_o      <= 1'b1;
                  err_code_o <= ERR_OVF;
                  state      <= DISCARD;
                end else begin
                  acc <= acc_x10[VALUE_W-1:0];
                end
              end
              CLS_TERM: begin
                value_o       <= acc;
                value_valid_o <= 1'b1;
                state         <= IDLE;
              end
              CLS_PRINT: begin
                value_o       <= acc;
                value_valid_o <= 1'b1;
                char_o        <= rx_data_i;
                char_valid_o  <= 1'b1;
                state         <= IDLE;
              end
              default: begin
                err_o      <= 1'b1;
                err_code_o <= ERR_ILLEGAL;
                state      <= IDLE;
              end
            endcase
          end
          DISCARD: begin
            case (cls)
              CLS_DIGIT:   state <= DISCARD;
              CLS_PRINT:   begin char_o <= rx_data_i; char_valid_o <= 1'b1; state <= IDLE; end
              CLS_ILLEGAL: begin err_o <= 1'b1; err_code_o <= ERR_ILLEGAL; state <= IDLE; end
              default:     state <= IDLE;
            endcase
          end
          default: state <= IDLE;
        endcase
      end else if (expire) begin
        // An idle line ends a pending number; an overflowed one just goes quiet.
        if (state == NUM) begin
          value_o       <= acc;
          value_valid_o <= 1'b1;
        end
        state <= IDLE;
      end
    end
  end

`ifdef NUM_PARSER_ECHO_EN
  // One-entry echo buffer: a new byte is taken only when the slot is empty or draining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      echo_o       <= 8'h00;
      echo_valid_o <= 1'b0;
    end else if (rx_valid_i && !line_err && (!echo_valid_o || echo_ready_i)) begin
      echo_o       <= rx_data_i;
      echo_valid_o <= 1'b1;
    end else if (echo_ready_i) begin
      echo_valid_o <= 1'b0;
    end else begin
      echo_valid_o <= echo_valid_o;
    end
  end
`endif

endmodule

// File: tb/tb_uart_num_parser.sv
// Self-checking bench for uart_num_parser: directed vector table, corner sequences, random traffic vs a reference model.
module tb_uart_num_parser;

  localparam int VW = 32;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          pe = 1'b0;
  logic          fe = 1'b0;
  logic [VW-1:0] value;
  logic          vv;
  logic [7:0]    ch;
  logic          cv;
  logic          err;
  logic [1:0]    code;
  logic          busy;
`ifdef NUM_PARSER_ECHO_EN
  logic [7:0]    echo;
  logic          echo_valid;
  logic          echo_ready = 1'b1;
`endif

  always #5 clk = ~clk;

  uart_num_parser #(.VALUE_W(VW), .TIMEOUT_CYCLES(TO)) dut (
`ifdef NUM_PARSER_ECHO_EN
    .echo_o          (echo),
    .echo_valid_o    (echo_valid),
    .echo_ready_i    (echo_ready),
`endif
    .clk             (clk),
    .rst             (rst),
    .rx_valid_i      (rx_valid),
    .rx_data_i       (rx_data),
    .rx_parity_err_i (pe),
    .rx_frame_err_i  (fe),
    .value_o         (value),
    .value_valid_o   (vv),
    .char_o          (ch),
    .char_valid_o    (cv),
    .err_o           (err),
    .err_code_o      (code),
    .busy_o          (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: spec-level parser on whole bytes, timeout from cycle distance to last byte.
  int              cyc = 0;
  int              m_mode = 0;
  int              m_last = 0;
  longint unsigned m_acc = 0;
  logic [31:0]     m_value = '0;
  logic [7:0]      m_char = '0;
  logic [1:0]      m_code = '0;
  logic            e_vv = 1'b0, e_cv = 1'b0, e_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 25) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_dut();
    return {18'd0, vv, value, cv, ch, err, code, busy};
  endfunction

  function automatic logic [63:0] pack_model();
    return {18'd0, e_vv, m_value, e_cv, m_char, e_err, m_code, (m_mode != 0)};
  endfunction

  task automatic model_tick();
    bit dig, term, prt;
    longint unsigned n;
    cyc++;
    e_vv = 1'b0; e_cv = 1'b0; e_err = 1'b0;
    dig  = (rx_data >= 8'd48 && rx_data <= 8'd57);
    term = (rx_data == 8'd10 || rx_data == 8'd13 || rx_data == 8'd32);
    prt  = (rx_data >= 8'd33 && rx_data <= 8'd126 && !dig);
    if (!rst) begin
      m_mode = 0; m_acc = 0; m_value = '0; m_char = '0; m_code = '0;
    end else if (rx_valid) begin
      m_last = cyc;
      if (pe || fe) begin
        e_err = 1'b1; m_code = 2'd1; m_mode = 0;
      end else if (m_mode == 0) begin
        if (dig) begin m_acc = longint'(rx_data) - 48; m_mode = 1; end
        else if (prt) begin e_cv = 1'b1; m_char = rx_data; end
        else if (!term) begin e_err = 1'b1; m_code = 2'd3; end
      end else if (m_mode == 1) begin
        if (dig) begin
          n = m_acc * 10 + (longint'(rx_data) - 48);
          if (n > 64'hFFFF_FFFF) begin e_err = 1'b1; m_code = 2'd2; m_mode = 2; end
          else m_acc = n;
        end else if (term) begin
          e_vv = 1'b1; m_value = m_acc[31:0]; m_mode = 0;
        end else if (prt) begin
          e_vv = 1'b1; m_value = m_acc[31:0]; e_cv = 1'b1; m_char = rx_data; m_mode = 0;
        end else begin
          e_err = 1'b1; m_code = 2'd3; m_mode = 0;
        end
      end else begin
        if (!dig) begin
          m_mode = 0;
          if (prt) begin e_cv = 1'b1; m_char = rx_data; end
          else if (!term) begin e_err = 1'b1; m_code = 2'd3; end
        end
      end
    end else if (m_mode != 0 && cyc - m_last == TO) begin
      if (m_mode == 1) begin e_vv = 1'b1; m_value = m_acc[31:0]; end
      m_mode = 0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic f, input logic r);
    rst = r; rx_valid = v; rx_data = d; pe = p; fe = f;
    @(posedge clk);
    model_tick();
    #1;
    check($sformatf("model_cyc%0d", cyc), pack_dut(), pack_model());
    rst = 1'b1; rx_valid = 1'b0; pe = 1'b0; fe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic        pe, fe;
    logic        vv;
    logic [31:0] val;
    logic        cv;
    logic [7:0]  ch;
    logic        err;
    logic [1:0]  code;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [7:0] d, input logic p, input logic f,
                              input logic evv, input logic [31:0] val,
                              input logic ecv, input logic [7:0] c,
                              input logic eerr, input logic [1:0] ec);
    vec_t r;
    r.d = d; r.pe = p; r.fe = f; r.vv = evv; r.val = val;
    r.cv = ecv; r.ch = c; r.err = eerr; r.code = ec;
    tbl.push_back(r);
  endfunction

  function automatic void add_quiet(input string s);
    for (int i = 0; i < s.len(); i++) add(s[i], 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'h00, 1'b0, 2'd0);
  endfunction

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 15);
    if (r < 7)       b = 8'($urandom_range(48, 57));
    else if (r < 9)  begin
      r = $urandom_range(0, 2);
      b = (r == 0) ? 8'h0A : ((r == 1) ? 8'h0D : 8'h20);
    end
    else if (r < 12) begin
      b = 8'($urandom_range(33, 126));
      if (b >= 8'd48 && b <= 8'd57) b = 8'h7A;
    end
    else if (r < 14) b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(127, 255)) : 8'($urandom_range(0, 8));
    else             b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    logic [31:0] got;
    logic [7:0] b;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_outputs", pack_dut(), 64'd0);
    idle(2);

    // Directed vector table (bytes back-to-back)
    add(8'h68, 0, 0, 0, 0, 1, 8'h68, 0, 0);
    add(8'h69, 0, 0, 0, 0, 1, 8'h69, 0, 0);
    add(8'h0F, 0, 0, 0, 0, 0, 8'h00, 1, 2'd3);
    add_quiet("5");
    add(8'h0D, 0, 0, 1, 32'd5, 0, 8'h00, 0, 0);
    add_quiet("7");
    add(8'h33, 0, 1, 0, 0, 0, 8'h00, 1, 2'd1);
    add_quiet("8");
    add(8'h20, 0, 0, 1, 32'd8, 0, 8'h00, 0, 0);
    add_quiet("429496729");
    add(8'h36, 0, 0, 0, 0, 0, 8'h00, 1, 2'd2);
    add_quiet("\r42");
    add(8'h0D, 0, 0, 1, 32'd42, 0, 8'h00, 0, 0);
    add_quiet("007");
    add(8'h78, 0, 0, 1, 32'd7, 1, 8'h78, 0, 0);
    add_quiet("0");
    add(8'h0A, 0, 0, 1, 32'd0, 0, 8'h00, 0, 0);
    add_quiet("4294967295");
    add(8'h0D, 0, 0, 1, 32'hFFFF_FFFF, 0, 8'h00, 0, 0);
    add(8'h7F, 0, 0, 0, 0, 0, 8'h00, 1, 2'd3);
    add(8'h21, 0, 0, 0, 0, 1, 8'h21, 0, 0);
    add(8'h7E, 0, 0, 0, 0, 1, 8'h7E, 0, 0);
    add_quiet(" 9");
    add(8'h80, 0, 0, 0, 0, 0, 8'h00, 1, 2'd3);
    add_quiet("999999999");
    add(8'h39, 0, 0, 0, 0, 0, 8'h00, 1, 2'd2);
    add_quiet("9");
    add(8'h41, 0, 0, 0, 0, 1, 8'h41, 0, 0);
    add(8'hFF, 0, 0, 0, 0, 0, 8'h00, 1, 2'd3);
    add_quiet("5");
    add(8'h31, 1, 0, 0, 0, 0, 8'h00, 1, 2'd1);
    add_quiet("\r");
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].d, tbl[i].pe, tbl[i].fe, 1'b1);
      check($sformatf("vec%0d", i),
            {vv, vv ? value : 32'd0, cv, cv ? ch : 8'd0, err, err ? code : 2'd0},
            {tbl[i].vv, tbl[i].val, tbl[i].cv, tbl[i].ch, tbl[i].err, tbl[i].code});
    end
    idle(TO + 2);

    // Idle timeout terminates a number exactly TO cycles after the last byte
    send_str("192");
    found = -1; got = '0;
    for (int i = 1; i <= TO + 5; i++) begin
      idle(1);
      if (vv && found < 0) begin found = i; got = value; end
    end
    check("timeout_latency", 64'(found), 64'(TO));
    check("timeout_value", 64'(got), 64'd192);
    check("timeout_busy_low", 64'(busy), 64'd0);

    // Byte arriving on the expiry cycle wins over the timeout
    send_str("1");
    idle(TO - 1);
    step(1'b1, 8'h32, 1'b0, 1'b0, 1'b1);
    check("expiry_collision", {62'd0, vv, busy}, 64'd1);
    step(1'b1, 8'h0D, 1'b0, 1'b0, 1'b1);
    check("expiry_collision_value", {31'd0, vv, value}, {31'd0, 1'b1, 32'd12});

    // Overflowed number times out silently
    send_str("99999999999");
    found = 0;
    for (int i = 0; i < TO + 3; i++) begin
      idle(1);
      if (vv) found++;
    end
    check("discard_timeout_silent", {63'(found), busy}, 64'd0);

    // Reset drops an in-flight number
    send_str("12");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("midnum_reset", pack_dut(), 64'd0);
    step(1'b1, 8'h0D, 1'b0, 1'b0, 1'b1);
    check("after_reset_cr", pack_dut(), 64'd0);

    // Randomised traffic against the reference model
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 199) == 0) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < 11; k++) step(1'b1, 8'($urandom_range(48, 57)), 1'b0, 1'b0, 1'b1);
      end
      b = rand_byte();
      if ($urandom_range(0, 19) == 0) step(1'b1, b, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      else step(1'b1, b, 1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 19) == 0) idle($urandom_range(TO - 2, TO + 2));
      else idle($urandom_range(0, 2));
    end
    idle(TO + 2);

`ifdef NUM_PARSER_ECHO_EN
    // Echo buffer holds the first byte while the consumer stalls
    echo_ready = 1'b0;
    send_str("abc");
    check("echo_hold", {55'd0, echo_valid, echo}, {55'd0, 1'b1, 8'h61});
    echo_ready = 1'b1;
    idle(1);
    check("echo_release", {63'd0, echo_valid}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
